multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: COUNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: Run  input  1  permits a new fetch to begin.
REQ-005 Port: OP  input  6  opcode, Instruction[31:26], from the instruction register.
REQ-006 Port: MemReady  input  1  unified memory has completed the current read/write this cycle.
REQ-007 Port: PCWrite, PCWriteCondEQ, PCWriteCondNE  output  1 each  unconditional / beq / bne PC write enables.
REQ-008 Port: IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  standard multicycle datapath controls.
REQ-009 Port: ALUSrcB  output  2  B-mux select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
REQ-010 Port: PCSource  output  2  PC-mux select: 00 ALU result, 01 ALUOut register, 10 jump address.
REQ-011 Port: ALUOp  output  3  to ALUControl: 000 add, 001 sub, 010 or, 011 and, 100 lui, 111 funct-decoded.
REQ-012 Port: State  output  4  current state encoding, for debug.
REQ-013 Port: IllegalOp  output  1  unsupported opcode detected.
REQ-014 Port: InstrCount  output  COUNT_WIDTH  retired-instruction count.

Function
REQ-015 States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_COMPLETE 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_COMPLETE 11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-016 Default: every output not listed for a state SHALL be 0.
REQ-017 FETCH: MemRead=1, ALUSrcB=01, ALUOp=000; IRWrite = PCWrite = MemReady & Run; transition to DECODE only when MemReady & Run, otherwise hold.
REQ-018 DECODE: ALUSrcB=11, ALUOp=000; next state by OP: 0x00 -> EXECUTE; 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x08/0x0C/0x0D/0x0F -> IMM_EXEC; any other -> FETCH with IllegalOp=1 for that cycle.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; -> MEM_READ if OP=0x23, else MEM_WRITE.
REQ-020 MEM_READ: MemRead=1, IorD=1; hold until MemReady, then -> MEM_WB.
REQ-021 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
REQ-022 MEM_WRITE: MemWrite=1, IorD=1; hold until MemReady, then -> FETCH.
REQ-023 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=111; -> R_COMPLETE. R_COMPLETE: RegWrite=1, RegDst=1; -> FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWriteCondEQ=1 if OP=0x04, PCWriteCondNE=1 if OP=0x05; -> FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-026 IMM_EXEC: ALUSrcA=1, ALUSrcB=10; ALUOp = 000 (0x08), 011 (0x0C), 010 (0x0D), 100 (0x0F); -> IMM_COMPLETE. IMM_COMPLETE: RegWrite=1, RegDst=0; -> FETCH.
REQ-027 Zero-wait latency, FETCH to FETCH inclusive: lw 5, sw/R-type/immediate 4, branch/jump 3 cycles.
REQ-028 Memory signals (MemRead/MemWrite/IorD) SHALL remain stable for every cycle a wait state holds.
REQ-029 InstrCount SHALL increment by 1 on each edge leaving MEM_WB, MEM_WRITE (with MemReady), R_COMPLETE, BRANCH, JUMP or IMM_COMPLETE; wraps modulo 2^COUNT_WIDTH; illegal opcodes are not counted.
REQ-030 Run deasserted SHALL only stall in FETCH; an instruction in progress completes.

Reset
REQ-031 reset low SHALL immediately force State=FETCH and InstrCount=0, regardless of clk; combinational outputs follow FETCH decoding.
REQ-032 Reset mid-instruction abandons it without counting; no RegWrite/MemWrite/PCWrite SHALL occur after reset assertion.

Verification
REQ-033 R-type (OP=0x00), MemReady=1, Run=1 -> states 0,1,6,7,0; RegWrite=1, RegDst=1 in state 7; InstrCount 0->1.
REQ-034 lw (OP=0x23), MemReady low 3 cycles in MEM_READ -> state 3 held 3 cycles, MemRead=IorD=1 throughout; total 8 cycles; MemtoReg=1 in state 4.
REQ-035 bne (OP=0x05) -> state 8 with PCWriteCondNE=1, PCWriteCondEQ=0, PCSource=01, ALUOp=001; beq gives the converse.
REQ-036 OP=0x3F -> DECODE pulses IllegalOp=1, returns to FETCH, InstrCount unchanged.
REQ-037 Run=0 in FETCH for 5 cycles -> IRWrite=PCWrite=0, state held 0; reset pulsed low during MEM_WRITE -> State=0 asynchronously, InstrCount=0, MemWrite deasserted.
REQ-038 COUNT_WIDTH=4, 16 jumps (OP=0x02) -> InstrCount wraps 15->0, each jump 3 cycles with PCSource=10.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: FSM controller for a multicycle MIPS-style datapath.
// Also counts retired instructions.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Run,
  input  logic [5:0]             OP,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   PCWriteCondEQ,
  output logic                   PCWriteCondNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic [2:0]             ALUOp,
  output logic [3:0]             State,
  output logic                   IllegalOp,
  output logic [COUNT_WIDTH-1:0] InstrCount
);
  localparam logic [3:0] FETCH        = 4'd0;
  localparam logic [3:0] DECODE       = 4'd1;
  localparam logic [3:0] MEM_ADDR     = 4'd2;
  localparam logic [3:0] MEM_READ     = 4'd3;
  localparam logic [3:0] MEM_WB       = 4'd4;
  localparam logic [3:0] MEM_WRITE    = 4'd5;
  localparam logic [3:0] EXECUTE      = 4'd6;
  localparam logic [3:0] R_COMPLETE   = 4'd7;
  localparam logic [3:0] BRANCH       = 4'd8;
  localparam logic [3:0] JUMP         = 4'd9;
  localparam logic [3:0] IMM_EXEC     = 4'd10;
  localparam logic [3:0] IMM_COMPLETE = 4'd11;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  logic [3:0] next_state;
  logic       retire;
  logic       go;
  assign go = MemReady & Run;
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALUOp         = 3'b000;
    IllegalOp     = 1'b0;
    retire        = 1'b0;
    next_state    = FETCH;
    case (State)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        // Write enables are masked while reset is held so no PC/IR update leaks out.
        IRWrite    = go & reset;
        PCWrite    = go & reset;
        next_state = go ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (OP)
          OP_R:                             next_state = EXECUTE;
          OP_LW, OP_SW:                     next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:                   next_state = BRANCH;
          OP_J:                             next_state = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = IMM_EXEC;
          default:                          IllegalOp  = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (OP == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = MemReady ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        retire     = MemReady;
        next_state = MemReady ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 3'b111;
        next_state = R_COMPLETE;
      end
      R_COMPLETE: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 3'b001;
        PCSource      = 2'b01;
        PCWriteCondEQ = (OP == OP_BEQ);
        PCWriteCondNE = (OP == OP_BNE);
        retire        = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      IMM_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = (OP == OP_ANDI) ? 3'b011 : (OP == OP_ORI) ? 3'b010 : (OP == OP_LUI) ? 3'b100 : 3'b000;
        next_state = IMM_COMPLETE;
      end
      IMM_COMPLETE: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      State      <= FETCH;
      InstrCount <= '0;
    end else begin
      State <= next_state;
      if (retire) InstrCount <= InstrCount + COUNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the multicycle controller.
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b0, Run = 1'b0, MemReady = 1'b0;
  logic [5:0] OP = 6'h00;
  logic PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;
  logic [31:0] InstrCount;
  logic w_pcw, w_eq, w_ne, w_iord, w_mr, w_mw, w_irw, w_m2r, w_rd, w_rw, w_asa, w_ill;
  logic [1:0] w_asb, w_pcs;
  logic [2:0] w_aop;
  logic [3:0] w_st;
  logic [3:0] cnt4;
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_cnt = 0;
  typedef struct packed {logic [3:0] st; logic [5:0] op; logic rdy;} exp_t;
  exp_t q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .Run(Run), .OP(OP), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .State(State),
    .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  multicycle_control #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .Run(Run), .OP(OP), .MemReady(MemReady),
    .PCWrite(w_pcw), .PCWriteCondEQ(w_eq), .PCWriteCondNE(w_ne),
    .IorD(w_iord), .MemRead(w_mr), .MemWrite(w_mw), .IRWrite(w_irw),
    .MemtoReg(w_m2r), .RegDst(w_rd), .RegWrite(w_rw), .ALUSrcA(w_asa),
    .ALUSrcB(w_asb), .PCSource(w_pcs), .ALUOp(w_aop), .State(w_st),
    .IllegalOp(w_ill), .InstrCount(cnt4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    exp_t e;
    e.st = st;
    e.op = op;
    e.rdy = rdy;
    q.push_back(e);
  endtask

  // Expected state trace of one instruction, FETCH through its last state.
  task automatic push_instr(input logic [5:0] op, input int waits);
    push(4'd0, op, 1'b1);
    push(4'd1, op, 1'b1);
    case (op)
      6'h00: begin push(4'd6, op, 1'b1); push(4'd7, op, 1'b1); end
      6'h23: begin
        push(4'd2, op, 1'b1);
        repeat (waits) push(4'd3, op, 1'b0);
        push(4'd3, op, 1'b1);
        push(4'd4, op, 1'b1);
      end
      6'h2B: begin
        push(4'd2, op, 1'b1);
        repeat (waits) push(4'd5, op, 1'b0);
        push(4'd5, op, 1'b1);
      end
      6'h04, 6'h05: push(4'd8, op, 1'b1);
      6'h02: push(4'd9, op, 1'b1);
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin push(4'd10, op, 1'b1); push(4'd11, op, 1'b1); end
      default: ;
    endcase
  endtask

  function automatic logic retires(input exp_t e);
    return (e.st inside {4'd4, 4'd7, 4'd8, 4'd9, 4'd11}) || (e.st == 4'd5 && e.rdy);
  endfunction

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      6'h0C:   return 3'b011;
      6'h0D:   return 3'b010;
      6'h0F:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset();
    #3;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== 32'd0 || cnt4 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state state=%0d cnt=%0d cnt4=%0d want 0 0 0", State, InstrCount, cnt4);
    end
    n_checks++;
    if ({MemRead, ALUSrcB, ALUOp} !== 6'b1_01_000) begin
      n_fail++;
      $display("FAIL reset_decode MemRead/ALUSrcB/ALUOp=%b want 101000", {MemRead, ALUSrcB, ALUOp});
    end
    n_checks++;
    if ({RegWrite, MemWrite, PCWrite, IRWrite} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_writes got %b want 0000", {RegWrite, MemWrite, PCWrite, IRWrite});
    end
    step();
    reset = 1'b1;
    exp_cnt = 0;
    step();
    n_checks++;
    if (State !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release state=%0d want 0", State);
    end
  endtask

  task automatic test_rtype();
    exp_t e;
    push_instr(6'h00, 0);
    while (q.size() > 0) begin
      e = q.pop_front();
      OP = e.op; MemReady = e.rdy; Run = 1'b1;
      #1;
      n_checks++;
      if (State !== e.st) begin n_fail++; $display("FAIL rtype_state got %0d want %0d", State, e.st); end
      if (e.st == 4'd7) begin
        n_checks++;
        if ({RegWrite, RegDst} !== 2'b11) begin n_fail++; $display("FAIL rtype_wb RegWrite/RegDst=%b want 11", {RegWrite, RegDst}); end
      end
      step();
      if (retires(e)) exp_cnt++;
    end
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== 32'd1) begin
      n_fail++;
      $display("FAIL rtype_done state=%0d cnt=%0d want 0 1", State, InstrCount);
    end
  endtask

  task automatic test_lw_wait();
    exp_t e;
    int cycles = 0;
    push_instr(6'h23, 3);
    while (q.size() > 0) begin
      e = q.pop_front();
      OP = e.op; MemReady = e.rdy; Run = 1'b1;
      #1;
      cycles++;
      n_checks++;
      if (State !== e.st) begin n_fail++; $display("FAIL lw_state got %0d want %0d", State, e.st); end
      if (e.st == 4'd3) begin
        n_checks++;
        if ({MemRead, IorD, MemWrite} !== 3'b110) begin n_fail++; $display("FAIL lw_mem MemRead/IorD/MemWrite=%b want 110", {MemRead, IorD, MemWrite}); end
      end
      if (e.st == 4'd4) begin
        n_checks++;
        if ({MemtoReg, RegWrite, RegDst} !== 3'b110) begin n_fail++; $display("FAIL lw_wb MemtoReg/RegWrite/RegDst=%b want 110", {MemtoReg, RegWrite, RegDst}); end
      end
      step();
      if (retires(e)) exp_cnt++;
    end
    #1;
    n_checks++;
    if (cycles != 8 || State !== 4'd0 || InstrCount !== exp_cnt) begin
      n_fail++;
      $display("FAIL lw_done cycles=%0d state=%0d cnt=%0d want 8 0 %0d", cycles, State, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    push_instr(6'h05, 0);
    push_instr(6'h04, 0);
    while (q.size() > 0) begin
      e = q.pop_front();
      OP = e.op; MemReady = e.rdy; Run = 1'b1;
      #1;
      n_checks++;
      if (State !== e.st) begin n_fail++; $display("FAIL branch_state got %0d want %0d", State, e.st); end
      if (e.st == 4'd8) begin
        n_checks++;
        if ({PCWriteCondEQ, PCWriteCondNE, PCSource, ALUOp} !== {e.op == 6'h04, e.op == 6'h05, 2'b01, 3'b001}) begin
          n_fail++;
          $display("FAIL branch_ctl op=%h EQ/NE/PCSource/ALUOp=%b want %b", e.op,
                   {PCWriteCondEQ, PCWriteCondNE, PCSource, ALUOp}, {e.op == 6'h04, e.op == 6'h05, 5'b01001});
        end
      end
      step();
      if (retires(e)) exp_cnt++;
    end
    #1;
    n_checks++;
    if (InstrCount !== exp_cnt) begin n_fail++; $display("FAIL branch_cnt got %0d want %0d", InstrCount, exp_cnt); end
  endtask

  task automatic test_illegal();
    exp_t e;
    push_instr(6'h3F, 0);
    while (q.size() > 0) begin
      e = q.pop_front();
      OP = e.op; MemReady = e.rdy; Run = 1'b1;
      #1;
      n_checks++;
      if (State !== e.st) begin n_fail++; $display("FAIL illegal_state got %0d want %0d", State, e.st); end
      n_checks++;
      if (IllegalOp !== (e.st == 4'd1)) begin n_fail++; $display("FAIL illegal_flag state=%0d got %b want %b", e.st, IllegalOp, e.st == 4'd1); end
      step();
    end
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      n_fail++;
      $display("FAIL illegal_done state=%0d cnt=%0d want 0 %0d", State, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_run_stall();
    exp_t e;
    Run = 1'b0; MemReady = 1'b1; OP = 6'h00;
    repeat (5) begin
      #1;
      n_checks++;
      if ({State, IRWrite, PCWrite} !== 6'b0) begin
        n_fail++;
        $display("FAIL stall state=%0d IRWrite=%b PCWrite=%b want 0 0 0", State, IRWrite, PCWrite);
      end
      step();
    end
    push_instr(6'h00, 0);
    while (q.size() > 0) begin
      e = q.pop_front();
      OP = e.op; MemReady = e.rdy; Run = (e.st == 4'd0);
      #1;
      n_checks++;
      if (State !== e.st) begin n_fail++; $display("FAIL stall_mid_state got %0d want %0d", State, e.st); end
      step();
      if (retires(e)) exp_cnt++;
    end
    step();
    n_checks++;
    if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      n_fail++;
      $display("FAIL stall_hold state=%0d cnt=%0d want 0 %0d", State, InstrCount, exp_cnt);
    end
    Run = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic ok;
    push_instr(6'h00, 0);
    push_instr(6'h2B, 1);
    push_instr(6'h0D, 0);
    push_instr(6'h0C, 0);
    push_instr(6'h0F, 0);
    push_instr(6'h08, 0);
    push_instr(6'h23, 0);
    push_instr(6'h02, 0);
    push_instr(6'h04, 0);
    while (q.size() > 0) begin
      e = q.pop_front();
      OP = e.op; MemReady = e.rdy; Run = 1'b1;
      #1;
      n_checks++;
      if (State !== e.st) begin n_fail++; $display("FAIL b2b_state got %0d want %0d", State, e.st); end
      case (e.st)
        4'd0:    ok = MemRead && ALUSrcB == 2'b01 && ALUOp == 3'b000 && IRWrite && PCWrite;
        4'd1:    ok = ALUSrcB == 2'b11 && ALUOp == 3'b000 && !IllegalOp;
        4'd2:    ok = ALUSrcA && ALUSrcB == 2'b10 && ALUOp == 3'b000;
        4'd3:    ok = MemRead && IorD && !MemWrite;
        4'd4:    ok = RegWrite && MemtoReg && !RegDst;
        4'd5:    ok = MemWrite && IorD && !MemRead;
        4'd6:    ok = ALUSrcA && ALUSrcB == 2'b00 && ALUOp == 3'b111;
        4'd7:    ok = RegWrite && RegDst && !MemtoReg;
        4'd8:    ok = PCWriteCondEQ == (e.op == 6'h04) && PCWriteCondNE == (e.op == 6'h05) && PCSource == 2'b01 && ALUOp == 3'b001;
        4'd9:    ok = PCWrite && PCSource == 2'b10;
        4'd10:   ok = ALUSrcA && ALUSrcB == 2'b10 && ALUOp == imm_aluop(e.op);
        4'd11:   ok = RegWrite && !RegDst && !MemtoReg;
        default: ok = 1'b0;
      endcase
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ctl state=%0d op=%h got ctl=%b aluop=%b srcb=%b pcs=%b, required controls not all asserted",
                 e.st, e.op, {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA},
                 ALUOp, ALUSrcB, PCSource);
      end
      step();
      if (retires(e)) exp_cnt++;
      n_checks++;
      if (InstrCount !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got %0d want %0d", InstrCount, exp_cnt); end
    end
  endtask

  task automatic test_reset_midwrite();
    exp_t e;
    push_instr(6'h2B, 2);
    while (q.size() > 0) begin
      e = q.pop_front();
      OP = e.op; MemReady = e.rdy; Run = 1'b1;
      #1;
      n_checks++;
      if (State !== e.st) begin n_fail++; $display("FAIL midrst_state got %0d want %0d", State, e.st); end
      if (e.st == 4'd5) break;
      step();
    end
    q.delete();
    n_checks++;
    if (MemWrite !== 1'b1) begin n_fail++; $display("FAIL midrst_pre MemWrite=%b want 1", MemWrite); end
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== 32'd0 || cnt4 !== 4'd0 || MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async state=%0d cnt=%0d cnt4=%0d MemWrite=%b want 0 0 0 0", State, InstrCount, cnt4, MemWrite);
    end
    MemReady = 1'b1;
    repeat (2) begin
      step();
      n_checks++;
      if ({State, RegWrite, MemWrite, PCWrite} !== 7'b0) begin
        n_fail++;
        $display("FAIL midrst_hold state=%0d RegWrite/MemWrite/PCWrite=%b want 0 000", State, {RegWrite, MemWrite, PCWrite});
      end
    end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      push_instr(6'h02, 0);
      while (q.size() > 0) begin
        e = q.pop_front();
        OP = e.op; MemReady = e.rdy; Run = 1'b1;
        #1;
        n_checks++;
        if (State !== e.st) begin n_fail++; $display("FAIL wrap_state got %0d want %0d", State, e.st); end
        if (e.st == 4'd9) begin
          n_checks++;
          if ({PCWrite, PCSource} !== 3'b110) begin n_fail++; $display("FAIL wrap_jump PCWrite/PCSource=%b want 110", {PCWrite, PCSource}); end
        end
        step();
        if (retires(e)) exp_cnt++;
      end
      n_checks++;
      if (cnt4 !== 4'((j + 1) % 16)) begin n_fail++; $display("FAIL wrap_cnt4 jump %0d got %0d want %0d", j, cnt4, (j + 1) % 16); end
    end
    n_checks++;
    if (InstrCount !== 32'd16 || State !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_wide cnt=%0d state=%0d want 16 0", InstrCount, State);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_run_stall();
    test_back_to_back();
    test_reset_midwrite();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
